// File: rtl/branch_redirect_ctrl.sv
// Branch resolution receiver: queues resolved branches, updates the predictor, and on a mispredict flushes the ROB and redirects fetch.
// Optional stat counters are enabled with `define BRANCH_REDIRECT_STATS_EN.
module branch_redirect_ctrl #(
  parameter int QDEPTH    = 4,
  parameter int ROB_TAG_W = 6
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 bru_valid_in,
  output logic                 bru_ready_out,
  input  logic                 bru_taken_in,
  input  logic [18:0]          bru_offset_in,
  input  logic [63:0]          bru_pc_in,
  input  logic                 bru_pred_taken_in,
  input  logic [63:0]          bru_pred_target_in,
  input  logic [ROB_TAG_W-1:0] bru_rob_tag_in,
  output logic                 flush_out,
  output logic [ROB_TAG_W-1:0] flush_tag_out,
  output logic                 redirect_valid_out,
  output logic [63:0]          redirect_pc_out,
  input  logic                 fe_ready_in,
  output logic                 bp_update_valid_out,
  output logic [63:0]          bp_update_pc_out,
  output logic                 bp_update_taken_out,
`ifdef BRANCH_REDIRECT_STATS_EN
  output logic [63:0]          bp_update_target_out,
  output logic [31:0]          stat_branches_out,
  output logic [31:0]          stat_mispredicts_out
`else
  output logic [63:0]          bp_update_target_out
`endif
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  typedef struct packed {
    logic                 taken;
    logic [18:0]          offset;
    logic [63:0]          pc;
    logic                 pred_taken;
    logic [63:0]          pred_target;
    logic [ROB_TAG_W-1:0] tag;
  } entry_t;

  entry_t               fifo_q [QDEPTH];
  entry_t               head_s;
  logic [PTR_W:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]           state_q, state_d;
  logic                 empty_s, full_s, push_s, pop_s, mispredict_s;
  logic [63:0]          actual_pc_s;
  logic                 bp_valid_q, bp_valid_d, bp_taken_q, bp_taken_d;
  logic [63:0]          bp_pc_q, bp_pc_d, bp_target_q, bp_target_d;
  logic                 flush_q, flush_d, redir_valid_q, redir_valid_d;
  logic [ROB_TAG_W-1:0] flush_tag_q, flush_tag_d;
  logic [63:0]          redir_pc_q, redir_pc_d;

  assign empty_s       = (wr_ptr_q == rd_ptr_q);
  assign full_s        = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                         (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign bru_ready_out = !full_s && (state_q == ST_IDLE);
  assign push_s        = bru_valid_in && bru_ready_out;
  assign pop_s         = (state_q == ST_IDLE) && !empty_s;
  assign head_s        = fifo_q[rd_ptr_q[PTR_W-1:0]];
  // Offset is already a byte offset; the sum wraps modulo 2^64.
  assign actual_pc_s   = head_s.pc + {{45{head_s.offset[18]}}, head_s.offset};
  assign mispredict_s  = (head_s.taken != head_s.pred_taken) ||
                         (actual_pc_s != head_s.pred_target);

  always_ff @(posedge clk_in) begin
    if (push_s) begin
      fifo_q[wr_ptr_q[PTR_W-1:0]] <= '{bru_taken_in, bru_offset_in, bru_pc_in,
                                       bru_pred_taken_in, bru_pred_target_in,
                                       bru_rob_tag_in};
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q + {{PTR_W{1'b0}}, push_s};
    rd_ptr_d      = rd_ptr_q + {{PTR_W{1'b0}}, pop_s};
    bp_valid_d    = 1'b0;
    bp_taken_d    = bp_taken_q;
    bp_pc_d       = bp_pc_q;
    bp_target_d   = bp_target_q;
    flush_d       = 1'b0;
    flush_tag_d   = flush_tag_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          bp_valid_d  = 1'b1;
          bp_taken_d  = head_s.taken;
          bp_pc_d     = head_s.pc;
          bp_target_d = actual_pc_s;
          if (mispredict_s) begin
            state_d     = ST_FLUSH;
            flush_d     = 1'b1;
            flush_tag_d = head_s.tag;
            redir_pc_d  = actual_pc_s;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      // Everything still queued is younger than the mispredicted branch.
      ST_FLUSH: begin
        wr_ptr_d      = '0;
        rd_ptr_d      = '0;
        redir_valid_d = 1'b1;
        state_d       = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (fe_ready_in) begin
          redir_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          state_d = ST_REDIRECT;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        redir_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      bp_valid_q    <= 1'b0;
      bp_taken_q    <= 1'b0;
      bp_pc_q       <= 64'd0;
      bp_target_q   <= 64'd0;
      flush_q       <= 1'b0;
      flush_tag_q   <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 64'd0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      bp_valid_q    <= bp_valid_d;
      bp_taken_q    <= bp_taken_d;
      bp_pc_q       <= bp_pc_d;
      bp_target_q   <= bp_target_d;
      flush_q       <= flush_d;
      flush_tag_q   <= flush_tag_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign flush_out            = flush_q;
  assign flush_tag_out        = flush_tag_q;
  assign redirect_valid_out   = redir_valid_q;
  assign redirect_pc_out      = redir_pc_q;
  assign bp_update_valid_out  = bp_valid_q;
  assign bp_update_pc_out     = bp_pc_q;
  assign bp_update_taken_out  = bp_taken_q;
  assign bp_update_target_out = bp_target_q;

`ifdef BRANCH_REDIRECT_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stat_br_q <= 32'd0;
      stat_mp_q <= 32'd0;
    end else begin
      stat_br_q <= stat_br_q + {31'd0, pop_s};
      stat_mp_q <= stat_mp_q + {31'd0, pop_s && mispredict_s};
    end
  end

  assign stat_branches_out    = stat_br_q;
  assign stat_mispredicts_out = stat_mp_q;
`endif

endmodule
